// File: rtl/switch_reader.sv
// switch_reader
//
// Periodically scans a chain of external parallel-in/serial-out shift
// registers holding front-panel switch states and presents the last
// complete word.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   enable    in   continuous scanning permitted while high
//   sdata     in   serial data from the shift-register chain
//   sclk      out  shift clock to the chain (registered)
//   sload_n   out  parallel-load strobe to the chain, active-low (registered)
//   switches  out  last complete switch word, MSB = first bit shifted out
//   valid     out  one-cycle pulse: switches has just been updated
//   changed   out  one-cycle pulse with valid when the word differs
//   busy      out  high while a scan is in progress
//
// Parameters:
//   WIDTH     switch bits per scan
//   CLK_DIV   sclk half-period in clk cycles (1..255)
//   GAP       idle cycles between consecutive scans (0..65535)

module switch_reader #(
    parameter int WIDTH   = 24,
    parameter int CLK_DIV = 4,
    parameter int GAP     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sdata,
    output logic             sclk,
    output logic             sload_n,
    output logic [WIDTH-1:0] switches,
    output logic             valid,
    output logic             changed,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE,
        GAP_WAIT
    } state_t;

    // Bit counter must hold the value WIDTH itself (the terminal count).
    localparam int              BW       = $clog2(WIDTH + 1);
    localparam logic [7:0]      PH_LAST  = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH);
    localparam logic [15:0]     GAP_LAST = 16'(GAP);

    state_t             state_q, state_d;
    logic [7:0]         phase_q, phase_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [BW-1:0]      bit_inc;
    logic [15:0]        gap_q, gap_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   switches_q, switches_d;
    logic               valid_q, valid_d;
    logic               changed_q, changed_d;
    logic               busy_q, busy_d;
    logic               sclk_q, sclk_d;
    logic               sload_n_q, sload_n_d;
    // Holds off the first LOAD until the second clock edge after reset.
    logic               arm_q, arm_d;
    logic               phase_last;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        bit_inc    = bit_q + BW'(1);
        gap_d      = gap_q;
        shift_d    = shift_q;
        switches_d = switches_q;
        valid_d    = 1'b0;
        changed_d  = 1'b0;
        arm_d      = 1'b1;
        phase_last = (phase_q == PH_LAST);

        case (state_q)
            IDLE: begin
                if (enable && arm_q) begin
                    state_d = LOAD;
                    phase_d = 8'd0;
                end
            end
            LOAD: begin
                if (phase_last) begin
                    state_d = SHIFT_LO;
                    phase_d = 8'd0;
                    bit_d   = '0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            SHIFT_LO: begin
                if (phase_last) begin
                    // Sample at the end of the low phase; shifting left
                    // leaves the first bit in the MSB after WIDTH samples.
                    shift_d = (shift_q << 1) | WIDTH'(sdata);
                    state_d = SHIFT_HI;
                    phase_d = 8'd0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            SHIFT_HI: begin
                if (phase_last) begin
                    bit_d   = bit_inc;
                    phase_d = 8'd0;
                    state_d = (bit_inc == BIT_LAST) ? DONE : SHIFT_LO;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            DONE: begin
                // switches/valid/changed register here and appear on the
                // following cycle, together with the first post-scan state.
                switches_d = shift_q;
                valid_d    = 1'b1;
                changed_d  = (shift_q != switches_q);
                gap_d      = 16'd0;
                state_d    = (GAP > 0) ? GAP_WAIT : IDLE;
            end
            GAP_WAIT: begin
                // The first GAP_WAIT cycle carries the valid pulse; GAP
                // further idle cycles follow before returning to IDLE.
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Chain-facing outputs are decoded from the next state so the
        // registered pins line up with the state they belong to.
        sclk_d    = (state_d == SHIFT_HI);
        sload_n_d = (state_d != LOAD);
        busy_d    = (state_d == LOAD) || (state_d == SHIFT_LO) ||
                    (state_d == SHIFT_HI) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= 8'd0;
            bit_q      <= '0;
            gap_q      <= 16'd0;
            shift_q    <= '0;
            switches_q <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            busy_q     <= 1'b0;
            sclk_q     <= 1'b0;
            sload_n_q  <= 1'b1;
            arm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            shift_q    <= shift_d;
            switches_q <= switches_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            busy_q     <= busy_d;
            sclk_q     <= sclk_d;
            sload_n_q  <= sload_n_d;
            arm_q      <= arm_d;
        end
    end

    assign sclk     = sclk_q;
    assign sload_n  = sload_n_q;
    assign switches = switches_q;
    assign valid    = valid_q;
    assign changed  = changed_q;
    assign busy     = busy_q;

endmodule

// File: doc/switch_reader.md
SWITCH_READER -- requirements
Module: switch_reader

Interface
REQ-001 Parameter WIDTH, default 24: number of front-panel switch bits read per scan.
REQ-002 Parameter CLK_DIV, default 4: half-period of sclk in clk cycles; legal values are 1 to 255.
REQ-003 Parameter GAP, default 16: number of idle clk cycles between consecutive scans; legal values are 0 to 65535.
REQ-004 clk  input  1: system clock; all logic is clocked on its rising edge.
REQ-005 rst_n  input  1: reset; asynchronous, active-low.
REQ-006 enable  input  1: continuous scanning is permitted while this is high.
REQ-007 sdata  input  1: serial data from the external parallel-in/serial-out shift-register chain.
REQ-008 sclk  output  1: shift clock to the chain.
REQ-009 sload_n  output  1: parallel-load strobe to the chain, active-low.
REQ-010 switches  output  WIDTH: last complete switch word.
REQ-011 valid  output  1: one-cycle pulse; switches has just been updated.
REQ-012 changed  output  1: one-cycle pulse, coincident with valid, when the new word differs from the previous word.
REQ-013 busy  output  1: high whenever a scan is in progress.

Function
REQ-014 The FSM states shall be IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE and GAP_WAIT.
REQ-015 IDLE: sclk=0, sload_n=1, busy=0; if enable=1, the next state shall be LOAD.
REQ-016 LOAD: sload_n=0, sclk=0, busy=1 for exactly CLK_DIV cycles, then the next state shall be SHIFT_LO with bit count 0.
REQ-017 SHIFT_LO: sclk=0, sload_n=1 for CLK_DIV cycles; sdata shall be sampled in the last cycle of the phase.
REQ-018 SHIFT_HI: sclk=1 for CLK_DIV cycles, then the bit count shall increment.
REQ-019 At the end of SHIFT_HI, the next state shall be SHIFT_LO if the count is below WIDTH, and DONE if the count equals WIDTH.
REQ-020 Bit order: the first sampled bit shall land in switches[WIDTH-1] (MSB first); the last sampled bit shall land in switches[0].
REQ-021 Samples shall accumulate in an internal shift register; switches shall not change during a scan.
REQ-022 DONE lasts 1 cycle. In that cycle, switches shall load the assembled word and valid shall be 1.
REQ-023 In the DONE cycle, changed shall be 1 iff the assembled word differs from the prior switches value.
REQ-024 The first scan after reset shall compare against 0.
REQ-025 After DONE, the next state shall be GAP_WAIT when GAP>0 and IDLE when GAP=0.
REQ-026 GAP_WAIT: sclk=0, sload_n=1, busy=0 for GAP cycles, then the next state shall be IDLE.
REQ-027 Scan latency: valid shall assert exactly CLK_DIV*(1+2*WIDTH)+1 cycles after the first LOAD cycle (the LOAD cycle is cycle 0).
REQ-028 Deasserting enable mid-scan shall not abort the scan; the scan completes, valid pulses, and the FSM then rests in IDLE.
REQ-029 A new scan shall start only from IDLE.
REQ-030 The phase counter and bit counter shall be wide enough for the maximum legal CLK_DIV and WIDTH, and shall never wrap during a scan.
REQ-031 sclk and sload_n shall be driven directly from registers with no combinational glitches, and shall never be active simultaneously.

Reset
REQ-032 When rst_n is low, the outputs shall be: sclk=0, sload_n=1, switches=0, valid=0, changed=0, busy=0, and the FSM shall be in IDLE.
REQ-033 Reset asserted mid-scan shall abort immediately and discard the partial word; switches shall read 0.
REQ-034 After rst_n deasserts, the first LOAD shall begin no earlier than the second rising clk edge.

Verification
REQ-035 Basic scan, WIDTH=8, CLK_DIV=2, GAP=0: chain model holds 0xA5, enable held high -> switches=0xA5; valid and changed pulse 35 cycles after the first LOAD cycle; sload_n low for 2 cycles; 8 sclk high pulses of 2 cycles each.
REQ-036 Unchanged word: a second scan of 0xA5 -> valid pulses and changed=0.
REQ-037 Changed word: the chain switches to 0x5A -> valid=1 and changed=1.
REQ-038 Changed word on the next scan: the chain reads 0x01 -> switches=0x01, with bit order confirmed.
REQ-039 Gap timing, GAP=16: measure from valid to the next sload_n falling edge -> exactly 18 cycles (1 DONE to GAP_WAIT + 16 GAP + 1 IDLE).
REQ-040 Enable drop mid-scan: drop enable during bit 3 -> the scan completes with the correct word, then the FSM stays in IDLE with sclk=0 and sload_n=1 and no further LOAD.
REQ-041 Reset mid-scan: assert rst_n low during bit 5 of a 0xFF scan -> all outputs equal their reset values within the same cycle; after release, the next scan returns 0xFF with changed=1.
REQ-042 Extremes: WIDTH=24 and CLK_DIV=1 with alternating pattern 0xAAAAAA -> exact word returned with latency 50 cycles; assertion check that sclk and sload_n are never active together.
